// File: rtl/idct_1d_serial.sv
// 8-point serial 1-D inverse DCT.
// Coefficients X[0..7] are loaded one per handshake, then each output
// sample x[n] is built by eight multiply-accumulate steps on a single
// shared multiplier, scaled by 2^-10 (floor) and saturated to WIDTH+1 bits.
//
// state | meaning
// IDLE  | one cycle after reset before input is opened
// LOAD  | accepting X[kcnt], In_Ready high
// CALC  | accumulating buf[k]*coef(n,k) for k=0..7
// OUT   | x[n] presented, waiting for Out_Ready
module idct_1d_serial #(
  parameter int WIDTH = 8,
  parameter int A     = 362,
  parameter int B     = 502,
  parameter int C     = 473,
  parameter int D     = 426,
  parameter int E     = 284,
  parameter int F     = 196,
  parameter int G     = 100
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] In_Data,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH:0]   Out_Data,
  output logic             Out_Last
);

  localparam int PROD_W = WIDTH + 11;
  localparam int ACC_W  = WIDTH + 14;
  localparam int OUT_W  = WIDTH + 1;
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << WIDTH) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << WIDTH));

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUT} state_t;

  state_t                    state_q, state_d;
  logic [2:0]                kcnt_q, kcnt_d;
  logic [2:0]                n_q, n_d;
  logic [2:0]                k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic signed [WIDTH-1:0]   buf_q [8];
  logic signed [WIDTH-1:0]   buf_d [8];
  logic [OUT_W-1:0]          out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic                      in_ready_q, in_ready_d;

  logic [4:0]                m_wrap, m_fold, m_idx;
  logic                      neg;
  logic signed [10:0]        mag, coef;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_sum, shifted;
  logic [OUT_W-1:0]          sat;

  // Cosine constant for (n,k): fold the phase (2n+1)k mod 32 into the first
  // quadrant, tracking the sign flip, then pick the matching constant.
  always_comb begin
    m_wrap = 5'({n_q, 1'b1}) * 5'(k_q);
    m_fold = (m_wrap > 5'd16) ? 5'd0 - m_wrap : m_wrap;
    m_idx  = m_fold;
    neg    = 1'b0;
    if (m_fold > 5'd8) begin
      m_idx = 5'd16 - m_fold;
      neg   = 1'b1;
    end
    case (m_idx)
      5'd1:    mag = 11'(B);
      5'd2:    mag = 11'(C);
      5'd3:    mag = 11'(D);
      5'd5:    mag = 11'(E);
      5'd6:    mag = 11'(F);
      5'd7:    mag = 11'(G);
      default: mag = 11'(A);
    endcase
    if (k_q == 3'd0) begin
      mag = 11'(A);
      neg = 1'b0;
    end
    coef = neg ? -mag : mag;
  end

  // Shared multiplier, accumulate, floor-scale and saturate.
  always_comb begin
    prod    = PROD_W'(buf_q[k_q]) * PROD_W'(coef);
    acc_sum = acc_q + ACC_W'(prod);
    shifted = acc_sum >>> 10;
    if (shifted > SAT_HI)      sat = SAT_HI[OUT_W-1:0];
    else if (shifted < SAT_LO) sat = SAT_LO[OUT_W-1:0];
    else                       sat = shifted[OUT_W-1:0];
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    n_d         = n_q;
    k_d         = k_q;
    acc_d       = acc_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        state_d    = S_LOAD;
      end
      S_LOAD: begin
        if (In_Valid && in_ready_q) begin
          buf_d[kcnt_q] = In_Data;
          kcnt_d        = kcnt_q + 3'd1;
          if (kcnt_q == 3'd7) begin
            in_ready_d = 1'b0;
            n_d        = '0;
            k_d        = '0;
            acc_d      = '0;
            state_d    = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = acc_sum;
        k_d   = k_q + 3'd1;
        if (k_q == 3'd7) begin
          out_data_d  = sat;
          out_valid_d = 1'b1;
          out_last_d  = (n_q == 3'd7);
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (Out_Ready) begin
          out_valid_d = 1'b0;
          if (n_q != 3'd7) begin
            n_d     = n_q + 3'd1;
            k_d     = '0;
            acc_d   = '0;
            state_d = S_CALC;
          end else begin
            out_last_d = 1'b0;
            kcnt_d     = '0;
            in_ready_d = 1'b1;
            state_d    = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial block.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= S_IDLE;
      kcnt_q      <= '0;
      n_q         <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      n_q         <= n_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign In_Ready  = in_ready_q;
  assign Out_Valid = out_valid_q;
  assign Out_Data  = out_data_q;
  assign Out_Last  = out_last_q;

endmodule

// File: tb/tb_idct_1d_serial.sv
// Scoreboard bench for idct_1d_serial: a real-valued cosine reference model
// pushes expected samples, a negedge monitor pops them on each handshake.
module tb_idct_1d_serial;
  localparam int WIDTH = 8;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             In_Valid = 1'b0;
  logic             In_Ready;
  logic [WIDTH-1:0] In_Data = '0;
  logic             Out_Valid;
  logic             Out_Ready = 1'b0;
  logic [WIDTH:0]   Out_Data;
  logic             Out_Last;

  int checks = 0;
  int failures = 0;
  int out_cnt = 0;
  bit rand_rdy = 1'b0;
  bit hold = 1'b0;

  typedef struct {int data; bit last;} exp_t;
  exp_t exp_q[$];
  logic signed [WIDTH-1:0] blk [8];

  idct_1d_serial #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Data(Out_Data), .Out_Last(Out_Last)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // 0.5*cos((2n+1)k*pi/16) in Q10, with the k=0 term using A.
  function automatic int ref_coef(input int n, input int k);
    real r;
    if (k == 0) return 362;
    r = 512.0 * $cos(real'((2 * n + 1) * k) * 3.141592653589793 / 16.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  task automatic push_expected();
    int sum, v;
    exp_t e;
    for (int n = 0; n < 8; n++) begin
      sum = 0;
      for (int k = 0; k < 8; k++) sum += int'(blk[k]) * ref_coef(n, k);
      v = sum >>> 10;
      if (v > 255) v = 255;
      if (v < -256) v = -256;
      e.data = v;
      e.last = (n == 7);
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic send_block();
    int guard;
    push_expected();
    for (int i = 0; i < 8; i++) begin
      In_Valid = 1'b1;
      In_Data  = blk[i];
      guard = 0;
      while (!In_Ready) begin
        tick();
        guard++;
        if (guard > 500) begin
          $display("FAIL load_timeout: In_Ready stuck at %0d need 1", In_Ready);
          failures++;
          $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
          $fatal(1, "load timeout");
        end
      end
      tick();
    end
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      tick();
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick();
  endtask

  task automatic wait_outcnt(input int target);
    int guard = 0;
    while (out_cnt < target && guard < 2000) begin
      tick();
      guard++;
    end
    check("wait_outcnt", out_cnt, target);
  endtask

  // Out_Ready driver.
  initial begin
    forever begin
      @(posedge Clk);
      #1;
      Out_Ready = hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: a sample is consumed on the edge after it is seen with Out_Ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst_n && Out_Valid && Out_Ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", int'($signed(Out_Data)), 9999);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'($signed(Out_Data)), e.data);
          check("out_last", int'(Out_Last), int'(e.last));
        end
        out_cnt++;
      end
    end
  end

  initial begin
    int lat, base;
    logic [WIDTH:0] cap;

    // Reset behaviour
    repeat (2) @(posedge Clk);
    #1;
    check("rst_in_ready", int'(In_Ready), 0);
    check("rst_out_valid", int'(Out_Valid), 0);
    check("rst_out_data", int'(Out_Data), 0);
    check("rst_out_last", int'(Out_Last), 0);
    Rst_n = 1'b1;
    #1;
    check("idle_in_ready", int'(In_Ready), 0);
    tick();
    check("load_in_ready", int'(In_Ready), 1);

    // DC only, with latency
    foreach (blk[i]) blk[i] = '0;
    blk[0] = 8'sd64;
    send_block();
    lat = 0;
    while (!Out_Valid && lat < 50) begin
      tick();
      lat++;
    end
    check("first_latency", lat, 8);
    drain();

    foreach (blk[i]) blk[i] = '0;
    blk[0] = -8'sd64;
    send_block();
    drain();

    foreach (blk[i]) blk[i] = '0;
    blk[1] = 8'sd100;
    send_block();
    drain();

    foreach (blk[i]) blk[i] = 8'sd127;
    send_block();
    drain();

    foreach (blk[i]) blk[i] = -8'sd128;
    send_block();
    drain();

    // Stall on x[3]
    foreach (blk[i]) blk[i] = WIDTH'($urandom_range(0, 255));
    base = out_cnt;
    send_block();
    wait_outcnt(base + 3);
    hold = 1'b1;
    lat = 0;
    while (!Out_Valid && lat < 50) begin
      tick();
      lat++;
    end
    cap = Out_Data;
    repeat (5) begin
      tick();
      check("stall_valid", int'(Out_Valid), 1);
      check("stall_data", int'(Out_Data), int'(cap));
    end
    check("stall_no_advance", out_cnt, base + 3);
    hold = 1'b0;
    drain();

    // Random blocks, random backpressure, stray In_Valid during CALC
    rand_rdy = 1'b1;
    for (int b = 0; b < 6; b++) begin
      foreach (blk[i]) blk[i] = WIDTH'($urandom_range(0, 255));
      send_block();
      if (b % 2 == 1) begin
        repeat (6) begin
          In_Valid = 1'($urandom_range(0, 1));
          In_Data  = WIDTH'($urandom_range(0, 255));
          tick();
        end
        In_Valid = 1'b0;
      end
      drain();
    end
    rand_rdy = 1'b0;
    tick();

    // Reset during CALC of x[2]
    foreach (blk[i]) blk[i] = WIDTH'($urandom_range(0, 255));
    base = out_cnt;
    send_block();
    wait_outcnt(base + 2);
    repeat (3) tick();
    Rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_in_ready", int'(In_Ready), 0);
    check("midrst_out_valid", int'(Out_Valid), 0);
    check("midrst_out_data", int'(Out_Data), 0);
    check("midrst_out_last", int'(Out_Last), 0);
    tick();
    Rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", int'(In_Ready), 1);
    foreach (blk[i]) blk[i] = WIDTH'($urandom_range(0, 255));
    send_block();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
